mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter between the instruction-fetch requester and the data load/store requester of the rv64 core. Accepts at most one transaction at a time, presents it on a shared valid/ready memory request channel, waits for the memory response and routes it back to the owning requester. Sits between the `fetch`/execute stages and the unified memory model; it replaces the separate `imem_*`/`dmem_*` paths at `core_top` level.

## Interface
Parameters:
- `ADDR_W`, 64, address width
- `DATA_W`, 64, data width; `DATA_W/8` write-strobe bits

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous reset, active-high
- `ireq_valid_i`  in  1  fetch request valid (read-only)
- `ireq_ready_o`  out  1  fetch request accepted this cycle
- `ireq_addr_i`  in  ADDR_W  fetch address
- `iflush_i`  in  1  fetch redirect: drop any in-flight fetch response
- `iresp_valid_o`  out  1  fetch response valid, single cycle
- `dreq_valid_i`  in  1  data request valid
- `dreq_ready_o`  out  1  data request accepted this cycle
- `dreq_addr_i`  in  ADDR_W  data address
- `dreq_we_i`  in  1  1 = store, 0 = load
- `dreq_wdata_i`  in  DATA_W  store data
- `dreq_wstrb_i`  in  DATA_W/8  store byte enables
- `dresp_valid_o`  out  1  data response valid, single cycle (load data or store ack)
- `resp_rdata_o`  out  DATA_W  response data, shared by both requesters
- `mem_req_valid_o`  out  1  memory request valid
- `mem_req_ready_i`  in  1  memory accepts request
- `mem_addr_o`, `mem_we_o`, `mem_wdata_o`, `mem_wstrb_o`  out  ADDR_W/1/DATA_W/DATA_W/8  registered request fields
- `mem_resp_valid_i`  in  1  memory response valid
- `mem_rdata_i`  in  DATA_W  memory read data
- `busy_o`  out  1  state != IDLE

## Operation
- FSM: IDLE -> REQ -> RESP -> IDLE.
- IDLE: arbitrate. Winner's ready is combinational (`xreq_ready_o = IDLE && grant_x`); on accept, latch owner, addr, we, wdata, wstrb; go to REQ. Fetch is always latched with we=0, wstrb=0.
- REQ: `mem_req_valid_o`=1 with registered fields, held stable until `mem_req_ready_i`; then go to RESP.
- RESP: wait for `mem_resp_valid_i`; in that cycle forward combinationally: owner's `*resp_valid_o`=1, `resp_rdata_o`=`mem_rdata_i`; go to IDLE. Stores also complete on `mem_resp_valid_i`.
- Requesters cannot back-pressure responses.
- Flush: `iflush_i` while owner=fetch in REQ or RESP sets a drop flag. The memory request is still issued, never withdrawn. The response is consumed silently: `iresp_valid_o`=0. Flush in the same cycle as the response also suppresses it. Flush in IDLE, or with owner=data, has no effect. The drop flag clears on return to IDLE.
- `mem_resp_valid_i` outside RESP is ignored.
- `resp_rdata_o` is don't-care when both response valids are 0. Drive `mem_rdata_i` through unconditionally.

## Timing
- Reset values: state=IDLE, drop=0, last_grant=fetch, `mem_req_valid_o`=0, `*_ready_o`=0 when no valid, `*resp_valid_o`=0, `busy_o`=0, registered mem fields=0.
- Minimum latency: accept at cycle N; `mem_req_valid_o` at N+1. With ready at N+1 and response at N+2, the response reaches the requester at N+2. The next accept is possible at N+3.
- Peak throughput: one transaction per 3 cycles.
- `rst` mid-transaction: FSM to IDLE next edge, `mem_req_valid_o` low. The outstanding memory transaction is abandoned; memory must be reset alongside.
- Requester valid may drop before ready without side effects. The arbiter samples only in IDLE.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. When both valid in IDLE, grant the requester not in `last_grant`. `last_grant` updates on every accept.
- Undefined: fixed priority, data over fetch. The `last_grant` register is not built.

## Test plan
- Single fetch at 0x1000, memory ready immediately, response 2 cycles later with rdata 0x00000013_00000093 -> `iresp_valid_o` one cycle with that data; `busy_o` high for 2 cycles.
- Store addr 0x2000, wdata 0xDEADBEEF_CAFEF00D, wstrb 0x0F; memory holds ready low 3 cycles -> `mem_*` fields stable throughout REQ; `dresp_valid_o` on ack.
- Both requesters valid every cycle for 6 grants -> without the macro, all grants go to data. With `MEM_ARB_RR_EN` the order is data, fetch, data, fetch, data, fetch, since `last_grant` resets to fetch.
- Fetch accepted, `iflush_i` pulsed in REQ -> memory request still issued; response arrives; `iresp_valid_o` stays 0; next fetch returns normally.
- `rst` asserted in RESP, then stray `mem_resp_valid_i` -> state IDLE, no response valid asserted, new load at 0x3000 completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Single-port memory arbiter between the instruction-fetch
//               requester and the data load/store requester. One transaction
//               is in flight at a time. It is presented on a shared
//               valid/ready request channel, and the memory response is
//               routed back to the requester that owns the transaction.
//
//               The optional compile macro MEM_ARB_RR_EN selects round-robin
//               arbitration when both requesters are valid. When the macro is
//               undefined, arbitration is fixed priority with data over fetch.
//
// Ports       : clk, rst                 clock, synchronous active-high reset
//               ireq_* / iflush_i        fetch request channel and redirect
//               iresp_valid_o            fetch response strobe
//               dreq_*                   data load/store request channel
//               dresp_valid_o            data response strobe (load or ack)
//               resp_rdata_o             shared response data
//               mem_req_* / mem_*_o      registered memory request channel
//               mem_resp_valid_i/rdata   memory response
//               busy_o                   transaction in flight
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ireq_valid_i,
    output logic                  ireq_ready_o,
    input  logic [ADDR_W-1:0]     ireq_addr_i,
    input  logic                  iflush_i,
    output logic                  iresp_valid_o,

    input  logic                  dreq_valid_i,
    output logic                  dreq_ready_o,
    input  logic [ADDR_W-1:0]     dreq_addr_i,
    input  logic                  dreq_we_i,
    input  logic [DATA_W-1:0]     dreq_wdata_i,
    input  logic [DATA_W/8-1:0]   dreq_wstrb_i,
    output logic                  dresp_valid_o,

    output logic [DATA_W-1:0]     resp_rdata_o,

    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic                  mem_we_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    output logic [DATA_W/8-1:0]   mem_wstrb_o,
    input  logic                  mem_resp_valid_i,
    input  logic [DATA_W-1:0]     mem_rdata_i,

    output logic                  busy_o
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]           r_state;
    logic                 r_owner_d;   // 1 = data owns the current transaction
    logic                 r_drop;      // fetch response must be swallowed
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_we;
    logic [DATA_W-1:0]    r_wdata;
    logic [DATA_W/8-1:0]  r_wstrb;

    logic                 w_idle;
    logic                 w_grant_d;
    logic                 w_grant_i;
    logic                 w_accept;
    logic                 w_flush_hit;
    logic                 w_resp;

`ifdef MEM_ARB_RR_EN
    // Remembers the requester that won last; reset points at fetch so that the
    // first contested grant goes to data.
    logic                 r_last_d;

    always_comb begin
        w_grant_d = 1'b0;
        w_grant_i = 1'b0;
        if (dreq_valid_i && ireq_valid_i) begin
            w_grant_d = ~r_last_d;
            w_grant_i = r_last_d;
        end else begin
            w_grant_d = dreq_valid_i;
            w_grant_i = ireq_valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_d <= 1'b0;
        end else if (w_accept) begin
            r_last_d <= w_grant_d;
        end
    end
`else
    assign w_grant_d = dreq_valid_i;
    assign w_grant_i = ireq_valid_i & ~dreq_valid_i;
`endif

    assign w_idle      = (r_state == c_IDLE);
    assign w_accept    = w_idle & (w_grant_d | w_grant_i);
    // Only a fetch-owned transaction can be flushed; data traffic ignores it.
    assign w_flush_hit = iflush_i & ~r_owner_d;
    assign w_resp      = (r_state == c_RESP) & mem_resp_valid_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_owner_d <= 1'b0;
            r_drop    <= 1'b0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_owner_d <= w_grant_d;
                        r_drop    <= 1'b0;
                        r_state   <= c_REQ;
                        if (w_grant_d) begin
                            r_addr  <= dreq_addr_i;
                            r_we    <= dreq_we_i;
                            r_wdata <= dreq_wdata_i;
                            r_wstrb <= dreq_wstrb_i;
                        end else begin
                            // Fetches are always reads.
                            r_addr  <= ireq_addr_i;
                            r_we    <= 1'b0;
                            r_wdata <= '0;
                            r_wstrb <= '0;
                        end
                    end
                end
                c_REQ: begin
                    // The memory request is never withdrawn once presented;
                    // a flush only marks the eventual response for dropping.
                    if (w_flush_hit) begin
                        r_drop <= 1'b1;
                    end
                    if (mem_req_ready_i) begin
                        r_state <= c_RESP;
                    end
                end
                c_RESP: begin
                    if (w_flush_hit) begin
                        r_drop <= 1'b1;
                    end
                    if (mem_resp_valid_i) begin
                        r_state <= c_IDLE;
                        r_drop  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign ireq_ready_o    = w_idle & w_grant_i;
    assign dreq_ready_o    = w_idle & w_grant_d;

    // A flush arriving in the response cycle itself also suppresses it.
    assign iresp_valid_o   = w_resp & ~r_owner_d & ~r_drop & ~iflush_i;
    assign dresp_valid_o   = w_resp & r_owner_d;
    assign resp_rdata_o    = mem_rdata_i;

    assign mem_req_valid_o = (r_state == c_REQ);
    assign mem_addr_o      = r_addr;
    assign mem_we_o        = r_we;
    assign mem_wdata_o     = r_wdata;
    assign mem_wstrb_o     = r_wstrb;

    assign busy_o          = ~w_idle;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. Directed scenarios are
//               followed by randomized traffic. Each cycle is checked against
//               a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ireq_valid_i, ireq_ready_o, iflush_i, iresp_valid_o;
    logic [63:0] ireq_addr_i;
    logic        dreq_valid_i, dreq_ready_o, dreq_we_i, dresp_valid_o;
    logic [63:0] dreq_addr_i, dreq_wdata_i;
    logic [7:0]  dreq_wstrb_i;
    logic [63:0] resp_rdata_o;
    logic        mem_req_valid_o, mem_req_ready_i, mem_we_o;
    logic [63:0] mem_addr_o, mem_wdata_o;
    logic [7:0]  mem_wstrb_o;
    logic        mem_resp_valid_i;
    logic [63:0] mem_rdata_i;
    logic        busy_o;

    mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk              (clk),
        .rst              (rst),
        .ireq_valid_i     (ireq_valid_i),
        .ireq_ready_o     (ireq_ready_o),
        .ireq_addr_i      (ireq_addr_i),
        .iflush_i         (iflush_i),
        .iresp_valid_o    (iresp_valid_o),
        .dreq_valid_i     (dreq_valid_i),
        .dreq_ready_o     (dreq_ready_o),
        .dreq_addr_i      (dreq_addr_i),
        .dreq_we_i        (dreq_we_i),
        .dreq_wdata_i     (dreq_wdata_i),
        .dreq_wstrb_i     (dreq_wstrb_i),
        .dresp_valid_o    (dresp_valid_o),
        .resp_rdata_o     (resp_rdata_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_addr_o       (mem_addr_o),
        .mem_we_o         (mem_we_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_wstrb_o      (mem_wstrb_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_rdata_i      (mem_rdata_i),
        .busy_o           (busy_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one outstanding transaction, described by whether it
    // exists, whether memory has taken it, who owns it, and its fields.
    logic        m_busy, m_issued, m_owner_d, m_drop, m_last_d;
    logic [63:0] m_addr, m_wdata;
    logic        m_we;
    logic [7:0]  m_wstrb;

    // Observations gathered by step() for the directed scenarios.
    int          n_iresp, n_dresp, n_busy;
    logic        s_accepted, s_accept_d;
    logic [63:0] s_rdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        ireq_valid_i     = 1'b0;
        ireq_addr_i      = '0;
        iflush_i         = 1'b0;
        dreq_valid_i     = 1'b0;
        dreq_addr_i      = '0;
        dreq_we_i        = 1'b0;
        dreq_wdata_i     = '0;
        dreq_wstrb_i     = '0;
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_rdata_i      = '0;
    endtask

    // Check one cycle against the model, then advance the model and the clock.
    task automatic step();
        logic ge_d, ge_i, resp_now, exp_i, exp_d;
        @(negedge clk);
        ge_d = 1'b0;
        ge_i = 1'b0;
        if (!m_busy) begin
            if (dreq_valid_i && ireq_valid_i) begin
`ifdef MEM_ARB_RR_EN
                ge_d = !m_last_d;
`else
                ge_d = 1'b1;
`endif
                ge_i = !ge_d;
            end else begin
                ge_d = dreq_valid_i;
                ge_i = ireq_valid_i;
            end
        end
        resp_now = m_busy && m_issued && mem_resp_valid_i;
        exp_i    = resp_now && !m_owner_d && !m_drop && !iflush_i;
        exp_d    = resp_now && m_owner_d;

        check("dreq_ready", 64'(dreq_ready_o), 64'(ge_d));
        check("ireq_ready", 64'(ireq_ready_o), 64'(ge_i));
        check("busy", 64'(busy_o), 64'(m_busy));
        check("mem_req_valid", 64'(mem_req_valid_o), 64'(m_busy && !m_issued));
        check("iresp_valid", 64'(iresp_valid_o), 64'(exp_i));
        check("dresp_valid", 64'(dresp_valid_o), 64'(exp_d));
        if (m_busy && !m_issued) begin
            check("mem_addr", mem_addr_o, m_addr);
            check("mem_we", 64'(mem_we_o), 64'(m_we));
            check("mem_wdata", mem_wdata_o, m_wdata);
            check("mem_wstrb", 64'(mem_wstrb_o), 64'(m_wstrb));
        end
        if (exp_i || exp_d) begin
            check("resp_rdata", resp_rdata_o, mem_rdata_i);
        end

        if (busy_o) n_busy++;
        if (iresp_valid_o) begin n_iresp++; s_rdata = resp_rdata_o; end
        if (dresp_valid_o) begin n_dresp++; s_rdata = resp_rdata_o; end
        s_accepted = ireq_ready_o | dreq_ready_o;
        s_accept_d = dreq_ready_o;

        if (rst) begin
            m_busy = 1'b0; m_issued = 1'b0; m_drop = 1'b0; m_last_d = 1'b0;
        end else if (!m_busy) begin
            if (ge_d) begin
                m_busy = 1'b1; m_issued = 1'b0; m_drop = 1'b0;
                m_owner_d = 1'b1; m_last_d = 1'b1;
                m_addr = dreq_addr_i; m_we = dreq_we_i;
                m_wdata = dreq_wdata_i; m_wstrb = dreq_wstrb_i;
            end else if (ge_i) begin
                m_busy = 1'b1; m_issued = 1'b0; m_drop = 1'b0;
                m_owner_d = 1'b0; m_last_d = 1'b0;
                m_addr = ireq_addr_i; m_we = 1'b0;
                m_wdata = '0; m_wstrb = '0;
            end
        end else begin
            if (iflush_i && !m_owner_d) m_drop = 1'b1;
            if (!m_issued) begin
                if (mem_req_ready_i) m_issued = 1'b1;
            end else if (mem_resp_valid_i) begin
                m_busy = 1'b0;
                m_drop = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int base;
        logic exp_grant_d;

        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_busy = 1'b0; m_issued = 1'b0; m_owner_d = 1'b0; m_drop = 1'b0; m_last_d = 1'b0;
        m_addr = '0; m_we = 1'b0; m_wdata = '0; m_wstrb = '0;
        n_iresp = 0; n_dresp = 0; n_busy = 0; s_rdata = '0;
        s_accepted = 1'b0; s_accept_d = 1'b0;

        // Reset state
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_mem_req_valid", 64'(mem_req_valid_o), 64'd0);
        check("rst_mem_addr", mem_addr_o, 64'd0);
        check("rst_mem_we", 64'(mem_we_o), 64'd0);
        check("rst_mem_wdata", mem_wdata_o, 64'd0);
        check("rst_mem_wstrb", 64'(mem_wstrb_o), 64'd0);
        check("rst_ireq_ready", 64'(ireq_ready_o), 64'd0);
        check("rst_dreq_ready", 64'(dreq_ready_o), 64'd0);
        check("rst_iresp", 64'(iresp_valid_o), 64'd0);
        check("rst_dresp", 64'(dresp_valid_o), 64'd0);

        // Single fetch at minimum latency
        n_busy = 0; n_iresp = 0;
        ireq_valid_i = 1'b1; ireq_addr_i = 64'h1000;
        step();
        check("t1_accept", 64'(s_accepted), 64'd1);
        ireq_valid_i = 1'b0; mem_req_ready_i = 1'b1;
        step();
        mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b1;
        mem_rdata_i = 64'h00000013_00000093;
        step();
        mem_resp_valid_i = 1'b0;
        step();
        check("t1_busy_cycles", 64'(n_busy), 64'd2);
        check("t1_iresp_count", 64'(n_iresp), 64'd1);
        check("t1_rdata", s_rdata, 64'h00000013_00000093);

        // Store with memory stalling the request for 3 cycles
        n_dresp = 0;
        dreq_valid_i = 1'b1; dreq_addr_i = 64'h2000; dreq_we_i = 1'b1;
        dreq_wdata_i = 64'hDEADBEEF_CAFEF00D; dreq_wstrb_i = 8'h0F;
        step();
        clear_inputs();
        repeat (3) step();
        mem_req_ready_i = 1'b1;
        step();
        mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b1;
        step();
        mem_resp_valid_i = 1'b0;
        check("t2_dresp_count", 64'(n_dresp), 64'd1);

        // Both requesters valid continuously for 6 grants
        rst = 1'b1; step(); rst = 1'b0;
        ireq_valid_i = 1'b1; ireq_addr_i = 64'h4400;
        dreq_valid_i = 1'b1; dreq_addr_i = 64'h4800; dreq_we_i = 1'b0;
        mem_req_ready_i = 1'b1; mem_resp_valid_i = 1'b1;
        k = 0;
        for (int c = 0; c < 30 && k < 6; c++) begin
            step();
            if (s_accepted) begin
`ifdef MEM_ARB_RR_EN
                exp_grant_d = (k % 2 == 0);
`else
                exp_grant_d = 1'b1;
`endif
                check("t3_grant_order", 64'(s_accept_d), 64'(exp_grant_d));
                k++;
            end
        end
        check("t3_grant_count", 64'(k), 64'd6);
        clear_inputs();
        step();

        // Fetch flushed in REQ: request still issued, response swallowed
        base = n_iresp;
        ireq_valid_i = 1'b1; ireq_addr_i = 64'h5000;
        step();
        ireq_valid_i = 1'b0; iflush_i = 1'b1;
        step();
        iflush_i = 1'b0; mem_req_ready_i = 1'b1;
        step();
        mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b1; mem_rdata_i = 64'h1111;
        step();
        mem_resp_valid_i = 1'b0;
        check("t4_dropped", 64'(n_iresp - base), 64'd0);
        // Next fetch, with a flush during the IDLE accept cycle (no effect)
        ireq_valid_i = 1'b1; ireq_addr_i = 64'h5008; iflush_i = 1'b1;
        step();
        ireq_valid_i = 1'b0; iflush_i = 1'b0; mem_req_ready_i = 1'b1;
        step();
        mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b1; mem_rdata_i = 64'h2222;
        step();
        mem_resp_valid_i = 1'b0;
        check("t4_next_fetch", 64'(n_iresp - base), 64'd1);
        check("t4_rdata", s_rdata, 64'h2222);

        // Reset in RESP, then a stray response, then a clean load
        base = n_dresp;
        dreq_valid_i = 1'b1; dreq_addr_i = 64'h6000; dreq_we_i = 1'b0;
        step();
        dreq_valid_i = 1'b0; mem_req_ready_i = 1'b1;
        step();
        mem_req_ready_i = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; mem_resp_valid_i = 1'b1; mem_rdata_i = 64'h3333;
        step();
        mem_resp_valid_i = 1'b0;
        check("t5_no_stray", 64'(n_dresp - base), 64'd0);
        dreq_valid_i = 1'b1; dreq_addr_i = 64'h3000;
        step();
        dreq_valid_i = 1'b0; mem_req_ready_i = 1'b1;
        step();
        mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b1; mem_rdata_i = 64'h0123_4567_89AB_CDEF;
        step();
        mem_resp_valid_i = 1'b0;
        check("t5_load_done", 64'(n_dresp - base), 64'd1);
        check("t5_rdata", s_rdata, 64'h0123_4567_89AB_CDEF);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst              = ($urandom_range(0, 199) == 0);
            ireq_valid_i     = $urandom_range(0, 1) == 1;
            ireq_addr_i      = {$urandom, $urandom};
            iflush_i         = ($urandom_range(0, 7) == 0);
            dreq_valid_i     = $urandom_range(0, 1) == 1;
            dreq_addr_i      = {$urandom, $urandom};
            dreq_we_i        = $urandom_range(0, 1) == 1;
            dreq_wdata_i     = {$urandom, $urandom};
            dreq_wstrb_i     = 8'($urandom);
            mem_req_ready_i  = $urandom_range(0, 1) == 1;
            mem_resp_valid_i = ($urandom_range(0, 2) == 0);
            mem_rdata_i      = {$urandom, $urandom};
            step();
        end
        clear_inputs();
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
